snake_color_sel: RTL and testbench
==================================

# snake_color_sel

Player-facing colour chooser for the snake game. Debounces the board push-buttons, lets the player step through the eight palette entries, and drives the 3-bit palette address into the colour lookup that returns body/head RGB444. Once the player confirms a choice, the address is locked for the rest of the game. It is unlocked again on game over. Sits between the button pins and the colour lookup, alongside the game-control FSM.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable samples required before a button level is accepted (≥1).
- `BLINK_CYCLES`, default 25_000_000: half-period of the preview blink, in clocks (≥1).
- `NUM_COLORS`, default 8: number of selectable palette entries (2..8).

Ports:
- `clk` in 1: system clock. One clock domain; reset is synchronous and active-high.
- `rst` in 1: synchronous, active-high reset.
- `btn_next` in 1: raw asynchronous button; advances the selection.
- `btn_prev` in 1: raw asynchronous button; steps the selection back.
- `btn_ok` in 1: raw asynchronous button; confirms the selection.
- `game_over` in 1: synchronous level from the game FSM; unlocks the selection.
- `color_addr` out 3: palette address fed to the colour lookup.
- `locked` out 1: selection confirmed; the game may start.
- `preview_on` out 1: show the snake preview. Blinks while selecting; held high while locked.

## Operation
- **Input conditioning, per button:**
  - 2-FF synchroniser.
  - Debounce counter resets whenever the synchronised level differs from the debounced level. When the counter reaches `DEBOUNCE_CYCLES - 1` with the level still different, the debounced level takes the new value and the counter clears.
  - A 1-cycle `*_pulse` is generated on each 0→1 transition of the debounced level.
- **FSM states:** SELECT (reset state) and LOCKED.
- **SELECT, evaluated each cycle in this priority:**
  - `ok_pulse`: go to LOCKED; `color_addr` is unchanged, even if next/prev pulse in the same cycle.
  - `next_pulse` and `prev_pulse` together: no change (see Configuration).
  - `next_pulse` alone: `color_addr` = `color_addr` + 1. From `NUM_COLORS - 1` it wraps to 0.
  - `prev_pulse` alone: `color_addr` = `color_addr` - 1. From 0 it wraps to `NUM_COLORS - 1`.
- **LOCKED:**
  - next/prev/ok pulses are ignored.
  - `game_over` = 1: go to SELECT; `color_addr` is retained.
- **Blink:**
  - In SELECT, the counter counts 0..`BLINK_CYCLES - 1`. At terminal count it wraps to 0 and `preview_on` toggles.
  - On entry to LOCKED, the counter clears and `preview_on` is forced to 1.
  - On re-entry to SELECT, blinking resumes from counter 0 with `preview_on` = 1.
- **Outputs:** `color_addr` is always < `NUM_COLORS`. `locked` = (state == LOCKED).

## Timing
- **Reset values:**
  - `color_addr` = 0, `locked` = 0, `preview_on` = 1.
  - State SELECT; all synchronisers, debounced levels, counters and pulses = 0.
  - LFSR = 8'h01 (when `COLOR_SEL_RAND_EN` is defined).
- **Press latency:** a raw button held high from the edge it is first sampled updates `color_addr`/`locked` at registered edge `DEBOUNCE_CYCLES + 3`. This is 2 synchroniser cycles + `DEBOUNCE_CYCLES` debounce + 1 action cycle.
- **Glitches:** a raw pulse shorter than `DEBOUNCE_CYCLES` synchronised samples produces no action. Bounce restarts the count.
- **Held buttons:** one action per press. Holding produces no repeat; release must also be debounced before the next press counts.
- **`game_over`:** acts on the edge where it is sampled high (1-cycle latency). If it is asserted in SELECT it has no effect.
- **Reset priority:** `rst` overrides everything on the same edge, including mid-debounce and mid-blink.

## Configuration
- **`COLOR_SEL_RAND_EN` defined:**
  - Adds an 8-bit Fibonacci LFSR (taps 8,6,5,4, seed 8'h01) that advances every clock.
  - In SELECT, `next_pulse` and `prev_pulse` in the same cycle load `color_addr` = `lfsr[2:0] % NUM_COLORS`, using the LFSR value registered before that edge.
  - `ok_pulse` still takes priority.
- **`COLOR_SEL_RAND_EN` undefined:** no LFSR; simultaneous next and prev leave `color_addr` unchanged.
- The port list is identical in both builds.

## Test plan
All scenarios use `DEBOUNCE_CYCLES` = 4, `BLINK_CYCLES` = 8, `NUM_COLORS` = 8.
- **Reset:** assert `rst` 2 cycles with buttons low → `color_addr` = 0, `locked` = 0, `preview_on` = 1. `preview_on` then toggles every 8 cycles.
- **Next and wrap:** hold `btn_next` 10 cycles → `color_addr` becomes 1 exactly 7 edges after first sample. 8 clean presses from 0 → returns to 0. 1 `btn_prev` press from 0 → 7.
- **Bounce rejection:** toggle `btn_next` high 3 cycles, low 1, high 3 → no change. Then hold 4+ cycles → +1 once only.
- **Confirm and lock:** at `color_addr` = 5, press `btn_ok` → `locked` = 1, `preview_on` = 1 steady, `color_addr` = 5. next/prev presses → still 5. Pulse `game_over` 1 cycle → `locked` = 0, `color_addr` = 5, blinking resumes.
- **Simultaneous events:** `btn_ok` and `btn_next` debounced in the same cycle → locked with the address unchanged. `btn_next` and `btn_prev` together → unchanged when the macro is undefined. When the macro is defined → `color_addr` = `lfsr[2:0]`, checked against a reference-model LFSR.
- **Reset mid-operation:** `rst` while LOCKED at `color_addr` = 6 and mid-debounce of `btn_prev` → all outputs return to reset values. The pending press is discarded.

Source files
------------

// File: rtl/snake_color_sel.sv
// Snake colour chooser: debounced next/prev/ok buttons step and lock a palette address.
// Define COLOR_SEL_RAND_EN to make simultaneous next+prev pick an LFSR-random entry.
module snake_color_sel #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int BLINK_CYCLES    = 25_000_000,
    parameter int NUM_COLORS      = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_next,
    input  logic       btn_prev,
    input  logic       btn_ok,
    input  logic       game_over,
    output logic [2:0] color_addr,
    output logic       locked,
    output logic       preview_on
);

    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [2:0] LAST = 3'(NUM_COLORS - 1);

    typedef enum logic {
        S_SELECT,
        S_LOCKED
    } state_t;

    logic [2:0]    w_raw;
    logic [2:0]    r_sync1;
    logic [2:0]    r_sync2;
    logic [2:0]    r_deb;
    logic [2:0]    r_pulse;
    logic [DW-1:0] r_dcnt [3];

    logic          w_next;
    logic          w_prev;
    logic          w_ok;

    state_t        r_state;
    logic [2:0]    r_addr;
    logic          r_locked;
    logic          r_preview;
    logic [BW-1:0] r_blink;

    assign w_raw  = {btn_ok, btn_prev, btn_next};
    assign w_next = r_pulse[0];
    assign w_prev = r_pulse[1];
    assign w_ok   = r_pulse[2];

    // Pulse is registered on the same edge the debounced level rises.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_deb   <= '0;
            r_pulse <= '0;
            for (int i = 0; i < 3; i++) r_dcnt[i] <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            for (int i = 0; i < 3; i++) begin
                r_pulse[i] <= 1'b0;
                if (r_sync2[i] == r_deb[i]) begin
                    r_dcnt[i] <= '0;
                end else if (r_dcnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    r_deb[i]   <= r_sync2[i];
                    r_pulse[i] <= r_sync2[i];
                    r_dcnt[i]  <= '0;
                end else begin
                    r_dcnt[i] <= r_dcnt[i] + DW'(1);
                end
            end
        end
    end

`ifdef COLOR_SEL_RAND_EN
    logic [7:0] r_lfsr;
    logic [2:0] w_rand;

    assign w_rand = 3'(r_lfsr[2:0] % NUM_COLORS);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= 8'h01;
        end else begin
            r_lfsr <= {r_lfsr[6:0],
                       r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_SELECT;
            r_addr    <= 3'd0;
            r_locked  <= 1'b0;
            r_preview <= 1'b1;
            r_blink   <= '0;
        end else begin
            unique case (r_state)
                S_SELECT: begin
                    if (w_ok) begin
                        r_state   <= S_LOCKED;
                        r_locked  <= 1'b1;
                        r_preview <= 1'b1;
                        r_blink   <= '0;
                    end else begin
                        if (r_blink == BW'(BLINK_CYCLES - 1)) begin
                            r_blink   <= '0;
                            r_preview <= ~r_preview;
                        end else begin
                            r_blink <= r_blink + BW'(1);
                        end
                        if (w_next && w_prev) begin
`ifdef COLOR_SEL_RAND_EN
                            r_addr <= w_rand;
`else
                            r_addr <= r_addr;
`endif
                        end else if (w_next) begin
                            r_addr <= (r_addr == LAST) ? 3'd0 : r_addr + 3'd1;
                        end else if (w_prev) begin
                            r_addr <= (r_addr == 3'd0) ? LAST : r_addr - 3'd1;
                        end
                    end
                end
                S_LOCKED: begin
                    r_blink   <= '0;
                    r_preview <= 1'b1;
                    if (game_over) begin
                        r_state  <= S_SELECT;
                        r_locked <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= S_SELECT;
                    r_locked <= 1'b0;
                end
            endcase
        end
    end

    assign color_addr = r_addr;
    assign locked     = r_locked;
    assign preview_on = r_preview;

endmodule

// File: tb/tb_snake_color_sel.sv
// Directed bench for snake_color_sel with DEBOUNCE_CYCLES=4, BLINK_CYCLES=8, NUM_COLORS=8.
// Inputs change 1ns after a rising edge; outputs are sampled at the same point.
module tb_snake_color_sel;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_next;
    logic       btn_prev;
    logic       btn_ok;
    logic       game_over;
    logic [2:0] color_addr;
    logic       locked;
    logic       preview_on;

    int n_pass = 0;
    int n_total = 0;
    logic [7:0] m_lfsr;

    snake_color_sel #(
        .DEBOUNCE_CYCLES(4),
        .BLINK_CYCLES(8),
        .NUM_COLORS(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_next(btn_next),
        .btn_prev(btn_prev),
        .btn_ok(btn_ok),
        .game_over(game_over),
        .color_addr(color_addr),
        .locked(locked),
        .preview_on(preview_on)
    );

    always #5 clk = ~clk;

    // Reference LFSR: taps 8,6,5,4, seed 8'h01, advances every clock.
    always @(posedge clk) begin
        if (rst) m_lfsr <= 8'h01;
        else m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Press: hold high long enough to debounce, then release and let release debounce.
    task automatic press(input int which);
        if (which == 0) btn_next = 1'b1;
        if (which == 1) btn_prev = 1'b1;
        if (which == 2) btn_ok = 1'b1;
        tick(8);
        btn_next = 1'b0;
        btn_prev = 1'b0;
        btn_ok   = 1'b0;
        tick(8);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        btn_next = 0; btn_prev = 0; btn_ok = 0; game_over = 0;
        rst = 1'b1;
        tick(2);
        n_total++;
        if (color_addr !== 3'd0) $display("FAIL reset_addr got %0d expected 0", color_addr);
        else n_pass++;
        n_total++;
        if (locked !== 1'b0) $display("FAIL reset_locked got %0b expected 0", locked);
        else n_pass++;
        n_total++;
        if (preview_on !== 1'b1) $display("FAIL reset_preview got %0b expected 1", preview_on);
        else n_pass++;
        rst = 1'b0;
        tick(7);
        n_total++;
        if (preview_on !== 1'b1) $display("FAIL blink_before got %0b expected 1", preview_on);
        else n_pass++;
        tick(1);
        n_total++;
        if (preview_on !== 1'b0) $display("FAIL blink_toggle1 got %0b expected 0", preview_on);
        else n_pass++;
        tick(8);
        n_total++;
        if (preview_on !== 1'b1) $display("FAIL blink_toggle2 got %0b expected 1", preview_on);
        else n_pass++;
    endtask

    task automatic test_next_wrap();
        btn_next = 1'b1;
        tick(6);
        n_total++;
        if (color_addr !== 3'd0) $display("FAIL latency_early got %0d expected 0", color_addr);
        else n_pass++;
        tick(1);
        n_total++;
        if (color_addr !== 3'd1) $display("FAIL latency_edge7 got %0d expected 1", color_addr);
        else n_pass++;
        tick(3);
        btn_next = 1'b0;
        tick(8);
        n_total++;
        if (color_addr !== 3'd1) $display("FAIL hold_no_repeat got %0d expected 1", color_addr);
        else n_pass++;
        for (int i = 0; i < 6; i++) press(0);
        n_total++;
        if (color_addr !== 3'd7) $display("FAIL next_to_7 got %0d expected 7", color_addr);
        else n_pass++;
        press(0);
        n_total++;
        if (color_addr !== 3'd0) $display("FAIL next_wrap got %0d expected 0", color_addr);
        else n_pass++;
        press(1);
        n_total++;
        if (color_addr !== 3'd7) $display("FAIL prev_wrap got %0d expected 7", color_addr);
        else n_pass++;
    endtask

    task automatic test_bounce();
        btn_next = 1'b1; tick(3);
        btn_next = 1'b0; tick(1);
        btn_next = 1'b1; tick(3);
        btn_next = 1'b0; tick(8);
        n_total++;
        if (color_addr !== 3'd7) $display("FAIL bounce_reject got %0d expected 7", color_addr);
        else n_pass++;
        btn_next = 1'b1; tick(12);
        btn_next = 1'b0; tick(8);
        n_total++;
        if (color_addr !== 3'd0) $display("FAIL bounce_then_hold got %0d expected 0", color_addr);
        else n_pass++;
    endtask

    task automatic test_lock();
        for (int i = 0; i < 5; i++) press(0);
        n_total++;
        if (color_addr !== 3'd5) $display("FAIL addr_5 got %0d expected 5", color_addr);
        else n_pass++;
        btn_ok = 1'b1;
        tick(6);
        n_total++;
        if (locked !== 1'b0) $display("FAIL lock_early got %0b expected 0", locked);
        else n_pass++;
        tick(1);
        n_total++;
        if (locked !== 1'b1) $display("FAIL lock_edge7 got %0b expected 1", locked);
        else n_pass++;
        n_total++;
        if (preview_on !== 1'b1) $display("FAIL lock_preview got %0b expected 1", preview_on);
        else n_pass++;
        btn_ok = 1'b0;
        tick(12);
        n_total++;
        if (preview_on !== 1'b1) $display("FAIL lock_preview_steady got %0b expected 1", preview_on);
        else n_pass++;
        press(0);
        press(1);
        n_total++;
        if (color_addr !== 3'd5) $display("FAIL lock_ignore got %0d expected 5", color_addr);
        else n_pass++;
        n_total++;
        if (locked !== 1'b1) $display("FAIL lock_hold got %0b expected 1", locked);
        else n_pass++;
        game_over = 1'b1; tick(1); game_over = 1'b0;
        n_total++;
        if (locked !== 1'b0) $display("FAIL unlock got %0b expected 0", locked);
        else n_pass++;
        n_total++;
        if (color_addr !== 3'd5) $display("FAIL unlock_addr got %0d expected 5", color_addr);
        else n_pass++;
        tick(7);
        n_total++;
        if (preview_on !== 1'b1) $display("FAIL reblink_before got %0b expected 1", preview_on);
        else n_pass++;
        tick(1);
        n_total++;
        if (preview_on !== 1'b0) $display("FAIL reblink_toggle got %0b expected 0", preview_on);
        else n_pass++;
        game_over = 1'b1; tick(1); game_over = 1'b0;
        n_total++;
        if (locked !== 1'b0 || color_addr !== 3'd5)
            $display("FAIL gameover_in_select got %0b/%0d expected 0/5", locked, color_addr);
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        logic [2:0] exp_addr;
        btn_ok = 1'b1; btn_next = 1'b1;
        tick(7);
        n_total++;
        if (locked !== 1'b1 || color_addr !== 3'd5)
            $display("FAIL ok_next got %0b/%0d expected 1/5", locked, color_addr);
        else n_pass++;
        btn_ok = 1'b0; btn_next = 1'b0;
        tick(8);
        game_over = 1'b1; tick(1); game_over = 1'b0;
        btn_next = 1'b1; btn_prev = 1'b1;
        tick(6);
`ifdef COLOR_SEL_RAND_EN
        exp_addr = m_lfsr[2:0];
`else
        exp_addr = 3'd5;
`endif
        tick(1);
        n_total++;
        if (color_addr !== exp_addr)
            $display("FAIL next_prev got %0d expected %0d", color_addr, exp_addr);
        else n_pass++;
        btn_next = 1'b0; btn_prev = 1'b0;
        tick(8);
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 6; i++) press(0);
        press(2);
        n_total++;
        if (locked !== 1'b1 || color_addr !== 3'd6)
            $display("FAIL pre_reset got %0b/%0d expected 1/6", locked, color_addr);
        else n_pass++;
        btn_prev = 1'b1;
        tick(4);
        rst = 1'b1; btn_prev = 1'b0;
        tick(1);
        rst = 1'b0;
        n_total++;
        if (color_addr !== 3'd0 || locked !== 1'b0 || preview_on !== 1'b1)
            $display("FAIL mid_reset got %0d/%0b/%0b expected 0/0/1",
                     color_addr, locked, preview_on);
        else n_pass++;
        tick(10);
        n_total++;
        if (color_addr !== 3'd0 || locked !== 1'b0)
            $display("FAIL pending_discard got %0d/%0b expected 0/0", color_addr, locked);
        else n_pass++;
    endtask

    initial begin
        rst = 1'b1;
        btn_next = 0; btn_prev = 0; btn_ok = 0; game_over = 0;
        #1;
        test_reset();
        test_next_wrap();
        test_bounce();
        test_lock();
        test_simultaneous();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
